// File: rtl/data_sel_pkg.sv
// Shared constants and helpers for the data distributor (1-to-N demultiplexer).
package data_sel_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int N_CH_DEF   = 4;

  localparam int             ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

  // One extra bit above the channel index leaves room for out-of-range and broadcast codes.
  function automatic int sel_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/distributor_slot.sv
// One-entry registered output slot of the data distributor; loads on demand and
// reports whether it can accept a word this cycle (empty or draining).
module distributor_slot
  import data_sel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              free
);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;

  assign free      = ~valid_r | out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Slot register: a load wins over a simultaneous drain, so throughput stays one word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/data_distributor.sv
// Clocked 1-to-N data distributor with per-channel one-entry slots and a saturating
// illegal-select counter. Define DATA_DISTRIBUTOR_BROADCAST_EN to make in_sel == N_CH a broadcast.
module data_distributor
  import data_sel_pkg::*;
#(
  parameter  int N_CH   = N_CH_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int SEL_W  = sel_w(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  logic [N_CH-1:0]      free_s;
  logic [N_CH-1:0]      hit_s;
  logic [N_CH-1:0]      load_s;
  logic                 bcast_s;
  logic                 drop_s;
  logic                 in_ready_s;
  logic [ERR_CNT_W-1:0] err_cnt_r;

  // Select decode: route to one slot, all slots (broadcast), or drop.
  always_comb begin
    hit_s      = '0;
    load_s     = '0;
    drop_s     = 1'b0;
    in_ready_s = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      hit_s[k] = (in_sel == SEL_W'(k));
    end
`ifdef DATA_DISTRIBUTOR_BROADCAST_EN
    bcast_s = (in_sel == SEL_W'(N_CH));
`else
    bcast_s = 1'b0;
`endif
    if (bcast_s) begin
      in_ready_s = &free_s;
      load_s     = {N_CH{in_valid & (&free_s)}};
    end else if (|hit_s) begin
      in_ready_s = |(hit_s & free_s);
      load_s     = hit_s & free_s & {N_CH{in_valid}};
    end else begin
      in_ready_s = 1'b1;
      drop_s     = in_valid;
    end
  end

  assign in_ready = in_ready_s;

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    distributor_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_s[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*DATA_W +: DATA_W]),
      .free      (free_s[k])
    );
  end

  // Dropped-word counter, sticks at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= '0;
    end else if (drop_s && (err_cnt_r != ERR_CNT_MAX)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;

endmodule

// File: doc/data_distributor.md
Name: data_distributor

Overview:
- Clocked 1-to-N data distributor (demultiplexer); the counterpart of the team's 2:1 data selector.
- Accepts one valid/ready input stream tagged with a channel select and routes each word to exactly one of N_CH output channels.
- Each output channel has a one-entry registered slot, so channels back-pressure independently.
- Sits between a shared producer and per-channel consumers.

Parameters:
- N_CH, 4, number of output channels (2..16).
- DATA_W, 8, data word width.
- SEL_W (localparam), $clog2(N_CH)+1, select width; the extra bit encodes out-of-range and broadcast codes.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  input word.
- in_sel  in  SEL_W  destination channel index; meaningful only while in_valid=1.
- in_valid  in  1  input word present.
- in_ready  out  1  input word accepted this cycle when in_valid&in_ready.
- out_data  out  N_CH*DATA_W  per-channel slot data; channel k is bits [k*DATA_W +: DATA_W].
- out_valid  out  N_CH  per-channel slot full.
- out_ready  in  N_CH  per-channel consumer ready.
- err_cnt  out  8  saturating count of words dropped because in_sel was illegal.

Behaviour:
- Reset (asynchronous, rst_n=0): all slots empty, out_valid=0, out_data=0, err_cnt=0. Reset mid-transfer discards held words; there is no partial state.
- Slot k drains when out_valid[k]&out_ready[k].
- Slot k can load this cycle when it is empty or draining: free[k] = ~out_valid[k] | out_ready[k].
- Legal select, in_sel < N_CH:
  - in_ready = free[in_sel]; combinational on in_sel and out_ready, no dependency on in_valid.
  - On accept, slot in_sel loads in_data; out_valid rises the next cycle. Latency is 1 clock.
- Simultaneous drain and load on the same slot:
  - The new word replaces the old one and out_valid stays 1.
  - Full throughput of 1 word/cycle per channel.
- Other channels are unaffected by a transfer; words to different channels interleave freely.
- Illegal select, in_sel >= N_CH (excluding the broadcast code when enabled):
  - in_ready=1; the word is consumed and dropped.
  - err_cnt increments by 1 on each such accept and saturates at 255.
- out_data[k] holds its value while out_valid[k]=1 and out_ready[k]=0.
- Ordering is preserved per channel. No ordering is guaranteed across channels.
- No state machine beyond the per-slot full flags. Slot state per channel: EMPTY -> FULL on load; FULL -> EMPTY on drain without load; FULL -> FULL on drain with load.

Optional Feature:
- Macro: DATA_DISTRIBUTOR_BROADCAST_EN.
- Defined:
  - in_sel == N_CH is the broadcast code.
  - in_ready = &free (all slots free or draining).
  - On accept, every slot loads in_data in the same cycle.
  - Broadcast is not counted as an error.
- Not defined: in_sel == N_CH is illegal and takes the drop/err_cnt path like any other out-of-range value.

Decomposition:
- Package data_sel_pkg:
  - DATA_W_DEF=8, N_CH_DEF=4.
  - ERR_CNT_W=8, ERR_CNT_MAX=8'hFF.
  - Function sel_w(n) returning $clog2(n)+1.
- Sub-module distributor_slot, instantiated N_CH times:
  - Ports: clk, rst_n, load, load_data, out_ready, out_valid, out_data, free.
  - Contains the one-entry register and the free computation.
- Top level holds the select decode, in_ready mux, broadcast logic and err_cnt.

Test Plan:
- Reset mid-stream:
  - Fill ch0 and ch2 (out_ready=0), then assert rst_n=0 without a clock.
  - Required: out_valid=4'b0000 and err_cnt=0 immediately.
- Single route:
  - in_sel=2, in_data=8'hA5, in_valid=1, all out_ready=0.
  - Required: accepted; next cycle out_valid=4'b0100 and ch2 data=A5.
  - A second word 8'h3C to ch2 sees in_ready=0 and A5 holds.
  - Raising out_ready[2] accepts 3C in the same cycle with out_valid[2] staying 1.
- Back-to-back throughput:
  - Ch1 out_ready=1 continuously; stream 8'h00..8'h0F to in_sel=1.
  - Required: in_ready=1 every cycle; ch1 delivers 00..0F in order, one per cycle, 1-cycle latency.
- Illegal select:
  - N_CH=4; send 300 words with in_sel=5.
  - Required: in_ready=1 every cycle, out_valid stays 0, err_cnt saturates at 255.
- Broadcast (macro defined):
  - in_sel=4, in_data=8'h77, out_ready=4'b1011 with all slots full.
  - Required: in_ready=0.
  - After out_ready[2]=1: accepted; next cycle all four channels show 77 with out_valid=4'b1111 and err_cnt unchanged.
  - With the macro undefined, the same word is dropped and err_cnt increments to 1.
